exu_stage: RTL and testbench
============================

Name: exu_stage

Overview:
- Parametrised execute stage between decode and writeback.
- Selects operands and runs the ALU op (add/sub/logic/shift/compare/pass), plus an optional iterative multiply.
- Holds the result in an output register under a valid/ready handshake on both sides.
- Successor to the fixed 32-bit single-result EXU: adds a width parameter, a registered output with back-pressure, and a multi-cycle MUL path.

Parameters:
XLEN, 32, datapath width (power of two, >=8)
RD_W, 5, destination register index width
MUL_EN, 1, 1 = iterative MUL op implemented; 0 = MUL op yields 0 in one cycle

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  decode offers an instruction
in_ready  output  1  stage accepts this cycle (handshake = in_valid & in_ready)
in_op  input  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 PASSB,11 MUL,12-15 reserved
in_op1_sel  input  1  0 = in_src1, 1 = in_pc
in_op2_sel  input  2  00 = zero-extended in_imm[log2(XLEN)-1:0]; 01 = in_src2; 10 = in_imm; 11 = constant XLEN/8
in_pc  input  XLEN  instruction address
in_src1  input  XLEN  register operand 1
in_src2  input  XLEN  register operand 2
in_imm  input  XLEN  sign-extended immediate
in_rd  input  RD_W  destination index
in_wen  input  1  instruction writes rd
out_valid  output  1  result available to writeback
out_ready  input  1  writeback consumes (transfer = out_valid & out_ready)
out_wdata  output  XLEN  result
out_rd  output  RD_W  destination index
out_wen  output  1  write enable, forced 0 when in_rd == 0
busy  output  1  multiply in progress

Behaviour:
- Reset (rst low, any time incl. mid-multiply): state IDLE; out_valid=0, out_wdata=0, out_rd=0, out_wen=0, busy=0, counter and accumulators cleared. in_ready=1 once rst is released.
- Operands: A per in_op1_sel, B per in_op2_sel. Shift ops use B[log2(XLEN)-1:0] only.
- Arithmetic: modulo 2^XLEN.
- SLT/SLTU: signed/unsigned A<B, result is 1 or 0 zero-extended.
- PASSB: result = B.
- Reserved ops: result 0, in single-cycle timing.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - BUSY: in_ready=0, out_valid=0, busy=1.
  - HOLD: out_valid=1, in_ready=out_ready.
- Transitions:
  - IDLE, accept non-MUL -> HOLD. Result, rd and wen are registered on the accept edge, so out_valid rises 1 cycle after accept.
  - IDLE, accept MUL (MUL_EN=1) -> BUSY. Latch A, B, rd, wen; counter=0.
  - BUSY: radix-2 shift-add, one multiplier bit per cycle. Counter increments each cycle. When counter==XLEN-1, register low XLEN bits of A*B and go to HOLD. out_valid therefore rises XLEN+1 cycles after accept.
  - HOLD, out_ready=0: all outputs stay bit-stable; no accept.
  - HOLD, out_ready=1, in_valid=0: -> IDLE.
  - HOLD, out_ready=1, in_valid=1, non-MUL: stay in HOLD with the new result. This gives back-to-back throughput of 1/cycle.
  - HOLD, out_ready=1, in_valid=1, MUL: -> BUSY.
- MUL_EN=0: op 11 behaves as a reserved op (result 0, single cycle); BUSY is unreachable.
- in_* may change freely when not accepted. Only values sampled at the accept edge matter, and BUSY never re-samples inputs.
- out_wen = in_wen & (in_rd != 0), captured at accept.

Test Plan:
- Reset then ADD: src1=5, src2=7, op2_sel=01 -> out_valid 1 cycle after accept; out_wdata=12; out_rd echoes in_rd; out_wen=1.
- PC+4 and x0 write: op1_sel=1, pc=0x80000000, op2_sel=11, op ADD, rd=0 -> out_wdata=0x80000004, out_wen=0.
- Compare and shift: SLT with A=0xFFFFFFFF, B=1 -> result 1. SLTU with the same operands -> 0. SRA of 0x80000000 by imm=4 (op2_sel=00) -> 0xF8000000. SLL by src2=33 -> shift by 1.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and outputs stable throughout. Then assert out_ready=1 with 3 queued ADDs -> 3 consecutive results, one per cycle.
- MUL: A=0x12345678, B=0x10 -> busy=1 for 32 cycles; out_valid at accept+33; out_wdata=0x23456780.
- Reset mid-MUL at cycle 10 of BUSY -> out_valid=0 and busy=0 immediately. A following ADD completes normally with no stale MUL result.

Source files
------------

// File: rtl/exu_stage.sv
`timescale 1ns/1ps
// Execute stage: operand select, single-cycle ALU and optional radix-2 iterative MUL, result held in an output register.
// Latency 1 cycle (MUL: XLEN+1); outputs hold bit-stable and input is stalled while out_ready is low.

module exu_stage #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter bit MUL_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_op,
  input  logic            in_op1_sel,
  input  logic [1:0]      in_op2_sel,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_wen,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_wdata,
  output logic [RD_W-1:0] out_rd,
  output logic            out_wen,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_HOLD} state_t;

  typedef struct packed {
    logic [XLEN-1:0] wdata;
    logic [RD_W-1:0] rd;
    logic            wen;
  } res_t;

  state_t          state_q, state_d;
  res_t            res_q, res_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [SHW-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0] op_a, op_b, alu_res, mul_sum;
  logic [SHW-1:0]  shamt;
  logic            accept, is_mul;

  assign accept    = in_valid & in_ready;
  assign is_mul    = MUL_EN && (in_op == 4'd11);
  assign out_wdata = res_q.wdata;
  assign out_rd    = res_q.rd;
  assign out_wen   = res_q.wen;

  always_comb begin
    op_a = in_op1_sel ? in_pc : in_src1;
    case (in_op2_sel)
      2'b00:   op_b = {{(XLEN-SHW){1'b0}}, in_imm[SHW-1:0]};
      2'b01:   op_b = in_src2;
      2'b10:   op_b = in_imm;
      default: op_b = XLEN'(XLEN / 8);
    endcase
    shamt = op_b[SHW-1:0];
  end

  // Op 11 lands in default: the MUL path bypasses this result entirely.
  always_comb begin
    alu_res = '0;
    case (in_op)
      4'd0:    alu_res = op_a + op_b;
      4'd1:    alu_res = op_a - op_b;
      4'd2:    alu_res = op_a & op_b;
      4'd3:    alu_res = op_a | op_b;
      4'd4:    alu_res = op_a ^ op_b;
      4'd5:    alu_res = op_a << shamt;
      4'd6:    alu_res = op_a >> shamt;
      4'd7:    alu_res = $signed(op_a) >>> shamt;
      4'd8:    alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9:    alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'd10:   alu_res = op_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    mul_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (state_q == S_HOLD && out_ready && !in_valid) state_d = S_IDLE;
        if (accept) begin
          res_d.rd  = in_rd;
          res_d.wen = in_wen && (in_rd != '0);
          if (is_mul) begin
            state_d  = S_BUSY;
            mcand_d  = op_a;
            mplier_d = op_b;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d     = S_HOLD;
            res_d.wdata = alu_res;
          end
        end
      end
      S_BUSY: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d.wdata = mul_sum;
          state_d     = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_BUSY: busy = 1'b1;
      S_HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exu_stage.sv
`timescale 1ns/1ps
// Directed-vector bench for exu_stage (XLEN=32, MUL_EN=1).

module tb_exu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic        in_op1_sel;
  logic [1:0]  in_op2_sel;
  logic [31:0] in_pc, in_src1, in_src2, in_imm;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid, out_ready;
  logic [31:0] out_wdata;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exu_stage #(.XLEN(32), .RD_W(5), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_pc(in_pc), .in_src1(in_src1), .in_src2(in_src2), .in_imm(in_imm),
    .in_rd(in_rd), .in_wen(in_wen),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wdata(out_wdata), .out_rd(out_rd), .out_wen(out_wen),
    .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic s1, input logic [1:0] s2,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [4:0] rd, input logic wen);
    in_op = op; in_op1_sel = s1; in_op2_sel = s2;
    in_pc = pc; in_src1 = a; in_src2 = b; in_imm = imm;
    in_rd = rd; in_wen = wen;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(4'd0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (out_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", out_wdata); end
    total++; if (out_rd !== 5'd0 || out_wen !== 1'b0) begin bad++; $display("FAIL reset_rd_wen got=%0d/%b exp=0/0", out_rd, out_wen); end
    rst = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add();
    drive(4'd0, 1'b0, 2'b01, 32'd0, 32'd5, 32'd7, 32'd0, 5'd3, 1'b1);
    in_valid = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL add_in_ready got=%b exp=1", in_ready); end
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b exp=1", out_valid); end
    total++; if (out_wdata !== 32'd12) begin bad++; $display("FAIL add_wdata got=%h exp=0000000c", out_wdata); end
    total++; if (out_rd !== 5'd3 || out_wen !== 1'b1) begin bad++; $display("FAIL add_rd_wen got=%0d/%b exp=3/1", out_rd, out_wen); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_pc_x0();
    drive(4'd0, 1'b1, 2'b11, 32'h8000_0000, 32'h1111_1111, 32'h2222_2222, 32'd0, 5'd0, 1'b1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_wdata !== 32'h8000_0004) begin bad++; $display("FAIL pc4_wdata got=%b/%h exp=1/80000004", out_valid, out_wdata); end
    total++; if (out_wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b exp=0", out_wen); end
    cyc();
  endtask

  task automatic test_alu_ops();
    logic [3:0]  vop  [12] = '{4'd8, 4'd9, 4'd7, 4'd5, 4'd1, 4'd6, 4'd4, 4'd2, 4'd3, 4'd10, 4'd13, 4'd0};
    logic [1:0]  vsel [12] = '{2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11};
    logic [31:0] va   [12] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'd5, 32'h8000_0000,
                               32'h0000_F0F0, 32'h0000_F0F0, 32'h0000_F0F0, 32'd9, 32'd5, 32'd10};
    logic [31:0] vb   [12] = '{32'd1, 32'd1, 32'd0, 32'd33, 32'd7, 32'd0,
                               32'h0000_FF00, 32'h0000_FF00, 32'h0000_FF00, 32'd0, 32'd7, 32'd0};
    logic [31:0] vimm [12] = '{32'd0, 32'd0, 32'hFFFF_FFE4, 32'd0, 32'd0, 32'h0000_0021,
                               32'd0, 32'd0, 32'd0, 32'hFFFF_F800, 32'd0, 32'd0};
    logic [31:0] vexp [12] = '{32'd1, 32'd0, 32'hF800_0000, 32'd6, 32'hFFFF_FFFE, 32'h4000_0000,
                               32'h0000_0FF0, 32'h0000_F000, 32'h0000_FFF0, 32'hFFFF_F800, 32'd0, 32'd14};
    for (int i = 0; i < 12; i++) begin
      drive(vop[i], 1'b0, vsel[i], 32'd0, va[i], vb[i], vimm[i], 5'(i + 1), 1'b1);
      in_valid = 1'b1;
      cyc();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_wdata !== vexp[i]) begin
        bad++; $display("FAIL alu_vec%0d op=%0d got=%b/%h exp=1/%h", i, vop[i], out_valid, out_wdata, vexp[i]);
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [3] = '{32'd11, 32'd23, 32'd34};
    logic [31:0] nxt_a [3] = '{32'd10, 32'd20, 32'd30};
    logic [31:0] nxt_b [3] = '{32'd1, 32'd3, 32'd4};
    out_ready = 1'b0;
    drive(4'd0, 1'b0, 2'b01, 32'd0, 32'd1, 32'd1, 32'd0, 5'd4, 1'b1);
    in_valid = 1'b1;
    cyc();
    drive(4'd0, 1'b0, 2'b01, 32'd0, nxt_a[0], nxt_b[0], 32'd0, 5'd5, 1'b1);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_wdata !== 32'd2 || out_rd !== 5'd4 || out_wen !== 1'b1) begin
        bad++; $display("FAIL stall_cyc%0d got rdy=%b vld=%b d=%h rd=%0d wen=%b exp rdy=0 vld=1 d=00000002 rd=4 wen=1",
                        i, in_ready, out_valid, out_wdata, out_rd, out_wen);
      end
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, 1'b0, 2'b01, 32'd0, nxt_a[i], nxt_b[i], 32'd0, 5'(5 + i), 1'b1);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready%0d got=%b exp=1", i, in_ready); end
      cyc();
      total++;
      if (out_valid !== 1'b1 || out_wdata !== exp_q[i] || out_rd !== 5'(5 + i)) begin
        bad++; $display("FAIL b2b_result%0d got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_wdata, out_rd, exp_q[i], 5 + i);
      end
    end
    in_valid = 1'b0;
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_mul();
    int lat, nbusy;
    drive(4'd11, 1'b0, 2'b01, 32'd0, 32'h1234_5678, 32'h0000_0010, 32'd0, 5'd7, 1'b1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    drive(4'd0, 1'b0, 2'b01, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 1'b0);
    lat = 1; nbusy = 0;
    while (out_valid !== 1'b1 && lat < 45) begin
      if (busy === 1'b1) nbusy++;
      cyc();
      lat++;
    end
    total++; if (lat != 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
    total++; if (nbusy != 32) begin bad++; $display("FAIL mul_busy_cycles got=%0d exp=32", nbusy); end
    total++; if (out_wdata !== 32'h2345_6780) begin bad++; $display("FAIL mul_wdata got=%h exp=23456780", out_wdata); end
    total++; if (out_rd !== 5'd7 || out_wen !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL mul_rd_wen_busy got=%0d/%b/%b exp=7/1/0", out_rd, out_wen, busy); end
    cyc();
  endtask

  task automatic test_mul_reset();
    int seen;
    drive(4'd11, 1'b0, 2'b01, 32'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 5'd8, 1'b1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    repeat (9) cyc();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mulrst_busy_before got=%b exp=1", busy); end
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mulrst_immediate got vld=%b busy=%b exp 0/0", out_valid, busy); end
    total++; if (out_wdata !== 32'd0) begin bad++; $display("FAIL mulrst_wdata got=%h exp=0", out_wdata); end
    cyc();
    rst = 1'b1;
    drive(4'd0, 1'b0, 2'b01, 32'd0, 32'd20, 32'd22, 32'd0, 5'd9, 1'b1);
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || out_wdata !== 32'd42 || out_rd !== 5'd9) begin bad++; $display("FAIL mulrst_add got=%b/%h/%0d exp=1/0000002a/9", out_valid, out_wdata, out_rd); end
    seen = 0;
    repeat (40) begin
      cyc();
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mulrst_stale got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_pc_x0();
    test_alu_ops();
    test_back_to_back();
    test_mul();
    test_mul_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
